// File: rtl/axi4_slave_mem_pkg.sv
// Shared constants, FSM state types and burst address helper for axi4_slave_mem.
package axi4_slave_mem_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
  typedef enum logic {StRIdle, StRData} r_state_e;

  // Address of the following beat; FIXED bursts stay put, INCR aligns then steps.
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [63:0] step;
    step = 64'd1 << size;
    if (burst == BurstFixed) return addr;
    return (addr & ~(step - 64'd1)) + step;
  endfunction

endpackage

// File: rtl/axi4_slave_mem_if.sv
// AXI4 bus bundle between an accelerator master and the slave memory.
interface axi4_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_slave_mem_array.sv
// Byte-strobed word array: two write ports (AXI wins over backdoor), two async read ports.
module axi4_slave_mem_array #(
  parameter int unsigned             DataWidth = 32,
  parameter int unsigned             MemWords  = 4096,
  parameter logic [DataWidth-1:0]    FillWord  = '1,
  localparam int unsigned            Bytes     = DataWidth / 8,
  localparam int unsigned            IdxW      = (MemWords > 1) ? $clog2(MemWords) : 1
) (
  input  logic                 clk_i,
  input  logic                 wa_we_i,
  input  logic [IdxW-1:0]      wa_idx_i,
  input  logic [DataWidth-1:0] wa_data_i,
  input  logic [Bytes-1:0]     wa_strb_i,
  input  logic                 wb_we_i,
  input  logic [IdxW-1:0]      wb_idx_i,
  input  logic [DataWidth-1:0] wb_data_i,
  input  logic [Bytes-1:0]     wb_strb_i,
  input  logic [IdxW-1:0]      ra_idx_i,
  output logic [DataWidth-1:0] ra_data_o,
  input  logic [IdxW-1:0]      rb_idx_i,
  output logic [DataWidth-1:0] rb_data_o
);

  // Words are stored XOR FillWord so power-up-zero storage reads back as the fill pattern
  // without a clearing pass; reset never touches the contents.
  logic [DataWidth-1:0] mem_q [MemWords];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Bytes; i++) begin
      if (wb_we_i && wb_strb_i[i]) begin
        mem_q[wb_idx_i][8*i +: 8] <= wb_data_i[8*i +: 8] ^ FillWord[8*i +: 8];
      end
      // Later assignment wins on a shared word/byte.
      if (wa_we_i && wa_strb_i[i]) begin
        mem_q[wa_idx_i][8*i +: 8] <= wa_data_i[8*i +: 8] ^ FillWord[8*i +: 8];
      end
    end
  end

  assign ra_data_o = mem_q[ra_idx_i] ^ FillWord;
  assign rb_data_o = mem_q[rb_idx_i] ^ FillWord;

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory with independent read/write burst FSMs and a backdoor access port.
module axi4_slave_mem
  import axi4_slave_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 1,
  parameter int unsigned           MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           FILL_VALUE = 32'hFFFFFFFF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  axi4_slave_mem_if.slave         axi_io,
  input  logic                    bd_we_i,
  input  logic [ADDR_WIDTH-1:0]   bd_addr_i,
  input  logic [DATA_WIDTH-1:0]   bd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] bd_wstrb_i,
  output logic [DATA_WIDTH-1:0]   bd_rdata_o
);

  localparam int unsigned Bytes     = DATA_WIDTH / 8;
  localparam int unsigned ByteShift = (Bytes > 1) ? $clog2(Bytes) : 0;
  localparam int unsigned IdxW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [63:0] MemBytes  = 64'(MEM_WORDS) * 64'(Bytes);
  localparam int unsigned FillReps  = (DATA_WIDTH + 31) / 32;
  localparam logic [FillReps*32-1:0] FillWide = {FillReps{FILL_VALUE}};
  localparam logic [DATA_WIDTH-1:0]  FillWord = FillWide[DATA_WIDTH-1:0];

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (64'(a) >= 64'(BASE_ADDR)) && ((64'(a) - 64'(BASE_ADDR)) < MemBytes);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IdxW'((64'(a) - 64'(BASE_ADDR)) >> ByteShift);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    return ADDR_WIDTH'(next_addr(64'(a), size, burst));
  endfunction

  function automatic logic xfer_bad(input logic [2:0] size, input logic [1:0] burst);
    return !(burst inside {BurstFixed, BurstIncr}) || (32'(size) > ByteShift);
  endfunction

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d, bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d, w_beat_q, w_beat_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d, bresp_q, bresp_d;
  logic                  w_bad_q, w_bad_d, w_dec_q, w_dec_d, w_slv_q, w_slv_d;
  logic                  w_last_beat, w_oor, w_dec_n, w_slv_n, mem_we;

  assign w_last_beat = (w_beat_q == aw_len_q);
  assign w_oor       = !addr_ok(aw_addr_q);

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_beat_d   = w_beat_q;
    w_bad_d    = w_bad_q;
    w_dec_d    = w_dec_q;
    w_slv_d    = w_slv_q;
    bresp_d    = bresp_q;
    bid_d      = bid_q;
    w_dec_n    = w_dec_q | w_oor;
    w_slv_n    = w_slv_q | w_bad_q | (axi_io.wlast != w_last_beat);
    mem_we     = 1'b0;
    unique case (w_state_q)
      StWIdle: begin
        if (axi_io.awvalid) begin
          w_state_d  = StWData;
          aw_id_d    = axi_io.awid;
          aw_addr_d  = axi_io.awaddr;
          aw_len_d   = axi_io.awlen;
          aw_size_d  = axi_io.awsize;
          aw_burst_d = axi_io.awburst;
          w_beat_d   = 8'd0;
          w_bad_d    = xfer_bad(axi_io.awsize, axi_io.awburst);
          w_dec_d    = 1'b0;
          w_slv_d    = 1'b0;
        end
      end
      StWData: begin
        if (axi_io.wvalid) begin
          mem_we  = !w_bad_q && !w_oor;
          w_dec_d = w_dec_n;
          w_slv_d = w_slv_n;
          // Length comes from awlen alone; a misplaced wlast only taints the response.
          if (w_last_beat) begin
            w_state_d = StWResp;
            bid_d     = aw_id_q;
            bresp_d   = w_dec_n ? RespDecerr : (w_slv_n ? RespSlverr : RespOkay);
          end else begin
            w_beat_d  = w_beat_q + 8'd1;
            aw_addr_d = step_addr(aw_addr_q, aw_size_q, aw_burst_q);
          end
        end
      end
      StWResp: begin
        if (axi_io.bready) w_state_d = StWIdle;
      end
      default: w_state_d = StWIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q  <= StWIdle;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_beat_q   <= '0;
      w_bad_q    <= 1'b0;
      w_dec_q    <= 1'b0;
      w_slv_q    <= 1'b0;
      bresp_q    <= RespOkay;
      bid_q      <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_beat_q   <= w_beat_d;
      w_bad_q    <= w_bad_d;
      w_dec_q    <= w_dec_d;
      w_slv_q    <= w_slv_d;
      bresp_q    <= bresp_d;
      bid_q      <= bid_d;
    end
  end

  assign axi_io.awready = (w_state_q == StWIdle);
  assign axi_io.wready  = (w_state_q == StWData);
  assign axi_io.bvalid  = (w_state_q == StWResp);
  assign axi_io.bresp   = bresp_q;
  assign axi_io.bid     = bid_q;

  // ---------------- read channel ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, rd_addr;
  logic [7:0]            ar_len_q, ar_len_d, r_beat_q, r_beat_d, r_beat_nxt;
  logic [2:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d, rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
  logic                  r_bad_q, r_bad_d, rlast_q, rlast_d;
  logic                  rd_ok, rd_bad, rd_last, rd_load;

  // Idle fetches the first beat straight from araddr so rvalid follows AR by one cycle.
  always_comb begin
    rd_addr = step_addr(ar_addr_q, ar_size_q, ar_burst_q);
    if (r_state_q == StRIdle) rd_addr = axi_io.araddr;
  end

  assign rd_ok      = addr_ok(rd_addr);
  assign r_beat_nxt = r_beat_q + 8'd1;

  always_comb begin
    r_state_d  = r_state_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_beat_d   = r_beat_q;
    r_bad_d    = r_bad_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    rd_bad     = r_bad_q;
    rd_last    = (r_beat_nxt == ar_len_q);
    rd_load    = 1'b0;
    unique case (r_state_q)
      StRIdle: begin
        rd_bad  = xfer_bad(axi_io.arsize, axi_io.arburst);
        rd_last = (axi_io.arlen == 8'd0);
        if (axi_io.arvalid) begin
          r_state_d  = StRData;
          ar_addr_d  = axi_io.araddr;
          ar_len_d   = axi_io.arlen;
          ar_size_d  = axi_io.arsize;
          ar_burst_d = axi_io.arburst;
          r_beat_d   = 8'd0;
          r_bad_d    = rd_bad;
          rid_d      = axi_io.arid;
          rd_load    = 1'b1;
        end
      end
      StRData: begin
        if (axi_io.rready) begin
          if (rlast_q) begin
            r_state_d = StRIdle;
            rlast_d   = 1'b0;
          end else begin
            r_beat_d  = r_beat_nxt;
            ar_addr_d = rd_addr;
            rd_load   = 1'b1;
          end
        end
      end
      default: r_state_d = StRIdle;
    endcase
    if (rd_load) begin
      rdata_d = (rd_ok && !rd_bad) ? rd_word : FillWord;
      rresp_d = !rd_ok ? RespDecerr : (rd_bad ? RespSlverr : RespOkay);
      rlast_d = rd_last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= StRIdle;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_beat_q   <= '0;
      r_bad_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      rlast_q    <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_beat_q   <= r_beat_d;
      r_bad_q    <= r_bad_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end

  assign axi_io.arready = (r_state_q == StRIdle);
  assign axi_io.rvalid  = (r_state_q == StRData);
  assign axi_io.rid     = rid_q;
  assign axi_io.rdata   = rdata_q;
  assign axi_io.rresp   = rresp_q;
  assign axi_io.rlast   = rlast_q;

  // ---------------- storage and backdoor ----------------
  logic            bd_ok;
  logic [DATA_WIDTH-1:0] bd_word;

  assign bd_ok = addr_ok(bd_addr_i);

  axi4_slave_mem_array #(
    .DataWidth (DATA_WIDTH),
    .MemWords  (MEM_WORDS),
    .FillWord  (FillWord)
  ) u_array (
    .clk_i     (clk_i),
    .wa_we_i   (mem_we),
    .wa_idx_i  (word_idx(aw_addr_q)),
    .wa_data_i (axi_io.wdata),
    .wa_strb_i (axi_io.wstrb),
    .wb_we_i   (bd_we_i && bd_ok),
    .wb_idx_i  (word_idx(bd_addr_i)),
    .wb_data_i (bd_wdata_i),
    .wb_strb_i (bd_wstrb_i),
    .ra_idx_i  (word_idx(rd_addr)),
    .ra_data_o (rd_word),
    .rb_idx_i  (word_idx(bd_addr_i)),
    .rb_data_o (bd_word)
  );

  assign bd_rdata_o = bd_ok ? bd_word : FillWord;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed self-checking bench for axi4_slave_mem using immediate assertions.
module tb_axi4_slave_mem;

  logic        clk;
  logic        rst_n;
  logic        bd_we;
  logic [31:0] bd_addr;
  logic [31:0] bd_wdata;
  logic [3:0]  bd_wstrb;
  logic [31:0] bd_rdata;

  int unsigned n_cmp;
  int unsigned n_fail;
  logic [31:0] wbuf [8];
  logic [31:0] exp_rd [4];

  axi4_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) bus ();

  axi4_slave_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ID_WIDTH   (1),
    .MEM_WORDS  (4096),
    .BASE_ADDR  (32'h0),
    .FILL_VALUE (32'hFFFFFFFF)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .axi_io     (bus),
    .bd_we_i    (bd_we),
    .bd_addr_i  (bd_addr),
    .bd_wdata_i (bd_wdata),
    .bd_wstrb_i (bd_wstrb),
    .bd_rdata_o (bd_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bd_addr = addr; bd_wdata = data; bd_wstrb = strb; bd_we = 1'b1;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic bd_peek(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bd_addr = addr;
    #1;
    check(tag, 64'(bd_rdata), 64'(exp));
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input int last_at, output logic [1:0] resp);
    int k;
    bus.awid = 1'b1; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd2;
    bus.awburst = burst; bus.awvalid = 1'b1;
    for (k = 0; k < 20 && !bus.awready; k++) tick();
    check("awready", 64'(bus.awready), 64'd1);
    tick();
    bus.awvalid = 1'b0;
    check("wready_after_aw", 64'(bus.wready), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = wbuf[i]; bus.wstrb = 4'hF; bus.wlast = (i == last_at); bus.wvalid = 1'b1;
      for (k = 0; k < 20 && !bus.wready; k++) tick();
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("bvalid_latency", 64'(bus.bvalid), 64'd1);
    check("bid", 64'(bus.bid), 64'd1);
    resp = bus.bresp;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("bvalid_drop", 64'(bus.bvalid), 64'd0);
  endtask

  task automatic axi_read1(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output logic last);
    bus.arid = 1'b0; bus.araddr = addr; bus.arlen = 8'd0; bus.arsize = 3'd2;
    bus.arburst = 2'b01; bus.arvalid = 1'b1;
    check("arready", 64'(bus.arready), 64'd1);
    tick();
    bus.arvalid = 1'b0;
    check("rvalid_latency", 64'(bus.rvalid), 64'd1);
    data = bus.rdata; resp = bus.rresp; last = bus.rlast;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("arready_back", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    logic        last;
    int          beats;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0; bd_wstrb = '0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_awready", 64'(bus.awready), 64'd1);
    check("rst_arready", 64'(bus.arready), 64'd1);
    check("rst_wready", 64'(bus.wready), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_rlast", 64'(bus.rlast), 64'd0);
    check("rst_bresp", 64'(bus.bresp), 64'd0);
    check("rst_rresp", 64'(bus.rresp), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    bd_peek("fill_at_zero", 32'h40, 32'hFFFFFFFF);
    tick();
    rst_n = 1'b1;
    tick();

    // Backdoor partial write then single-beat AXI read of the same word.
    bd_write(32'h40, 32'h11223344, 4'b0101);
    bd_peek("bd_strobe", 32'h40, 32'hFF22FF44);
    axi_read1(32'h40, data, resp, last);
    check("rd40_data", 64'(data), 64'hFF22FF44);
    check("rd40_resp", 64'(resp), 64'd0);
    check("rd40_last", 64'(last), 64'd1);

    // INCR write of four beats.
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    axi_write(32'h100, 8'd3, 2'b01, 3, resp);
    check("incr_bresp", 64'(resp), 64'd0);
    bd_peek("incr_w0", 32'h100, 32'd1);
    bd_peek("incr_w1", 32'h104, 32'd2);
    bd_peek("incr_w2", 32'h108, 32'd3);
    bd_peek("incr_w3", 32'h10C, 32'd4);

    // INCR read with rready toggling; data and rlast must hold across stalls.
    exp_rd[0] = 32'd1; exp_rd[1] = 32'd2; exp_rd[2] = 32'd3; exp_rd[3] = 32'd4;
    bus.araddr = 32'h100; bus.arlen = 8'd3; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check("burst_rvalid", 64'(bus.rvalid), 64'd1);
    beats = 0;
    for (int c = 0; c < 16 && bus.rvalid; c++) begin
      bus.rready = (c % 2 == 0);
      if (beats < 4) begin
        check("burst_rdata", 64'(bus.rdata), 64'(exp_rd[beats]));
        check("burst_rlast", 64'(bus.rlast), 64'(beats == 3));
      end
      if (bus.rready) beats++;
      tick();
    end
    bus.rready = 1'b0;
    check("burst_beats", 64'(beats), 64'd4);
    check("burst_done", 64'(bus.rvalid), 64'd0);

    // FIXED burst overwrites one word; WRAP is rejected without touching memory.
    wbuf[0] = 32'hA; wbuf[1] = 32'hB;
    axi_write(32'h200, 8'd1, 2'b00, 1, resp);
    check("fixed_bresp", 64'(resp), 64'd0);
    bd_peek("fixed_word", 32'h200, 32'hB);
    bd_peek("fixed_next", 32'h204, 32'hFFFFFFFF);
    wbuf[0] = 32'h5; wbuf[1] = 32'h6;
    axi_write(32'h300, 8'd1, 2'b10, 1, resp);
    check("wrap_bresp", 64'(resp), 64'd2);
    bd_peek("wrap_unchanged", 32'h300, 32'hFFFFFFFF);

    // wlast on the wrong beat: both beats land, response is SLVERR.
    wbuf[0] = 32'h7; wbuf[1] = 32'h8;
    axi_write(32'h700, 8'd1, 2'b01, 0, resp);
    check("wlast_bresp", 64'(resp), 64'd2);
    bd_peek("wlast_w1", 32'h704, 32'h8);

    // One past the end of the array.
    wbuf[0] = 32'h12345678;
    axi_write(32'h4000, 8'd0, 2'b01, 0, resp);
    check("oor_bresp", 64'(resp), 64'd3);
    axi_read1(32'h4000, data, resp, last);
    check("oor_rdata", 64'(data), 64'hFFFFFFFF);
    check("oor_rresp", 64'(resp), 64'd3);
    bd_peek("oor_bd", 32'h4000, 32'hFFFFFFFF);

    // Asynchronous reset in the middle of a burst.
    bus.awid = 1'b0; bus.awaddr = 32'h500; bus.awlen = 8'd3; bus.awsize = 3'd2;
    bus.awburst = 2'b01; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.wdata = 32'h55; bus.wlast = 1'b0;
    tick();
    bus.wdata = 32'h66;
    tick();
    bus.wvalid = 1'b0;
    check("mid_wready_pre", 64'(bus.wready), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_wready_rst", 64'(bus.wready), 64'd0);
    check("mid_awready_rst", 64'(bus.awready), 64'd1);
    bd_peek("mid_beat0", 32'h500, 32'h55);
    bd_peek("mid_beat1", 32'h504, 32'h66);
    tick();
    rst_n = 1'b1;
    tick();
    wbuf[0] = 32'h77;
    axi_write(32'h600, 8'd0, 2'b01, 0, resp);
    check("post_rst_bresp", 64'(resp), 64'd0);
    bd_peek("post_rst_word", 32'h600, 32'h77);
    bd_peek("post_rst_keep", 32'h500, 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
